// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/busy/done handshake with overflow flag.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] trial;

    always_comb begin
        // R stays below D between steps, so its top bit is always zero before the shift
        r_shift = (WIDTH+1)'({r_q, q_q[WIDTH-1]});
        trial   = {1'b0, r_shift} - {2'b00, d_q};

        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d = divisor;
                    if (divisor == '0 || dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                        quot_d = '1;
                        rem_d  = dividend[WIDTH-1:0];
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        r_d     = {1'b0, dividend[2*WIDTH-1:WIDTH]};
                        q_d     = dividend[WIDTH-1:0];
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = trial[WIDTH+1] ? r_shift : trial[WIDTH:0];
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == CALC);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed scenarios plus a randomized
// sweep compared against an arithmetic reference model.
module tb_seq_restoring_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy, done, ovf;
    logic [7:0]  quotient, remainder;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference: plain integer division; overflow when the quotient cannot fit in 8 bits.
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic o);
        int ia, ib, iq;
        ia = int'(a);
        ib = int'(b);
        if (ib == 0 || ia / ib > 255) begin
            q = 8'hFF;
            r = a[7:0];
            o = 1'b1;
        end else begin
            iq = ia / ib;
            q  = iq[7:0];
            iq = ia % ib;
            r  = iq[7:0];
            o  = 1'b0;
        end
    endfunction

    // Drive a one-cycle start; returns at the falling edge just after the sampling edge.
    task automatic pulse_start(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, quotient, remainder, ovf} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h ovf=%b, want all 0",
                     busy, done, quotient, remainder, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int n;
        pulse_start(16'd35, 8'd5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", n); end
        checks++;
        if ({quotient, remainder, ovf} !== {8'd7, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d ovf=%b want q=7 r=0 ovf=0", quotient, remainder, ovf);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_max;
        int n;
        pulse_start(16'hFEFF, 8'hFF);
        wait_done(n);
        checks++;
        if ({quotient, remainder, ovf} !== {8'hFF, 8'hFE, 1'b0}) begin
            errors++;
            $display("FAIL max_result: got q=%h r=%h ovf=%b want q=ff r=fe ovf=0", quotient, remainder, ovf);
        end
    endtask

    task automatic test_div_zero;
        pulse_start(16'd100, 8'd0);
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL divzero_handshake: got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        checks++;
        if ({quotient, remainder, ovf} !== {8'hFF, 8'h64, 1'b1}) begin
            errors++;
            $display("FAIL divzero_result: got q=%h r=%h ovf=%b want q=ff r=64 ovf=1", quotient, remainder, ovf);
        end
        pulse_start(16'h0100, 8'd1);
        checks++;
        if ({done, busy, quotient, remainder, ovf} !== {2'b10, 8'hFF, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL ovf_result: got done=%b busy=%b q=%h r=%h ovf=%b want 1 0 ff 00 1",
                     done, busy, quotient, remainder, ovf);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, ovf} !== 3'b001) begin
            errors++;
            $display("FAIL ovf_after: got done=%b busy=%b ovf=%b want 0 0 1 (ovf held)", done, busy, ovf);
        end
    endtask

    task automatic test_busy_ignore;
        int n;
        pulse_start(16'd200, 8'd7);
        @(negedge clk);
        dividend = 16'd9; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        checks++;
        if (n + 4 !== 8) begin errors++; $display("FAIL ignore_latency: got %0d want 8", n + 4); end
        checks++;
        if ({quotient, remainder, ovf} !== {8'd28, 8'd4, 1'b0}) begin
            errors++;
            $display("FAIL ignore_result: got q=%0d r=%0d ovf=%b want q=28 r=4 ovf=0", quotient, remainder, ovf);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_no_queue: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        pulse_start(16'h00E1, 8'd15);
        wait_done(n);
        dividend = 16'h0090; divisor = 8'd12; start = 1'b1;
        checks++;
        if ({n[7:0], quotient, remainder} !== {8'd8, 8'd15, 8'd0}) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want lat=8 q=15 r=0", n, quotient, remainder);
        end
        @(negedge clk);
        start = 1'b0;
        dividend = 16'hFFFF; divisor = 8'h00;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(n);
        checks++;
        if ({n[7:0], quotient, remainder, ovf} !== {8'd8, 8'd12, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d ovf=%b want lat=8 q=12 r=0 ovf=0",
                     n, quotient, remainder, ovf);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        pulse_start(16'd255, 8'd2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, ovf} !== 19'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got busy=%b done=%b q=%h r=%h ovf=%b want all 0",
                     busy, done, quotient, remainder, ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(16'd255, 8'd2);
        wait_done(n);
        checks++;
        if ({n[7:0], quotient, remainder, ovf} !== {8'd8, 8'd127, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL midrst_rerun: got lat=%0d q=%0d r=%0d ovf=%b want lat=8 q=127 r=1 ovf=0",
                     n, quotient, remainder, ovf);
        end
    endtask

    task automatic test_random_valid;
        int n, bad;
        logic [15:0] a;
        logic [7:0]  b, eq, er;
        logic        eo;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            b = 8'($urandom_range(1, 255));
            a = 16'($urandom_range(0, 255) * int'(b) + $urandom_range(0, int'(b) - 1));
            model(a, b, eq, er, eo);
            pulse_start(a, b);
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            wait_done(n);
            checks++;
            if (n !== 8 || {quotient, remainder, ovf} !== {eq, er, eo}
                || 32'(quotient) * 32'(b) + 32'(remainder) !== 32'(a) || remainder >= b) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_valid: %0d/%0d got lat=%0d q=%0d r=%0d ovf=%b want lat=8 q=%0d r=%0d ovf=%b",
                             a, b, n, quotient, remainder, ovf, eq, er, eo);
            end
        end
    endtask

    task automatic test_random_mixed;
        int n, want_lat, bad;
        logic [15:0] a;
        logic [7:0]  b, eq, er;
        logic        eo;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model(a, b, eq, er, eo);
            want_lat = eo ? 0 : 8;
            pulse_start(a, b);
            wait_done(n);
            checks++;
            if (n !== want_lat || {quotient, remainder, ovf} !== {eq, er, eo}) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_mixed: %0d/%0d got lat=%0d q=%0d r=%0d ovf=%b want lat=%0d q=%0d r=%0d ovf=%b",
                             a, b, n, quotient, remainder, ovf, want_lat, eq, er, eo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_max;
        test_div_zero;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_random_valid;
        test_random_mixed;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
